pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_seq_pkg.sv | 17 +
 rtl/pll_reset_sequencer_sync.sv | 34 +++
 rtl/pll_reset_sequencer.sv | 142 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg -- shared constants for the PLL reset sequencer.
// Holds the FSM state encoding (also exported on state_dbg), the width of
// the shared dwell counter and the width of the lock-loss event counter.
package pll_seq_pkg;

    localparam int CNT_W  = 17;  // dwell counter, covers RELOCK_TIMEOUT up to 65535
    localparam int LOSS_W = 8;   // lock_lost_count width

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_QUALIFY   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3,
        ST_PLL_RST   = 3'd4
    } state_e;

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_bit -- multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk   : destination clock
//   reset : synchronous active-high clear of every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
// STAGES must be at least 2.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer -- qualifies PLL lock on the board reference clock,
// holds the PLL-domain system reset until lock has been stable, re-pulses
// the PLL RESETB when lock does not arrive, and re-enters reset on loss.
// Ports:
//   clk             : 12 MHz reference clock (not the PLL output)
//   reset           : synchronous active-high reset
//   locked          : raw PLL LOCK (asynchronous, only seen via sync_bit)
//   soft_reset_req  : one-cycle request to re-pulse sys_reset (RUN only)
//   pll_resetb      : PLL RESETB, low only while in PLL_RST
//   sys_reset       : active-high reset for PLL-clocked logic
//   ready           : high only in RUN
//   lock_lost_count : saturating count of lock losses seen in RUN
//   state_dbg       : current state encoding
// Optional feature macro PLL_SEQ_LOSS_COUNT_EN: when undefined, the loss
// counter and state_dbg are tied to 0 and no counter flops exist.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int RELOCK_TIMEOUT     = 65535,
    parameter int PLL_RST_CYCLES     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              locked,
    input  logic              soft_reset_req,
    output logic              pll_resetb,
    output logic              sys_reset,
    output logic              ready,
    output logic [LOSS_W-1:0] lock_lost_count,
    output logic [2:0]        state_dbg
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RELOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);

    logic             locked_s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             pll_resetb_q, pll_resetb_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                if (locked_s)                   state_d = ST_QUALIFY;
                else if (cnt_q == TIMEOUT_LAST) state_d = ST_PLL_RST;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            ST_QUALIFY: begin
                if (!locked_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_HOLD;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            ST_HOLD: begin
                if (!locked_s)               state_d = ST_WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
                else                         cnt_d   = cnt_q + 1'b1;
            end
            ST_RUN: begin
                // Lock loss wins over a coincident soft reset request.
                if (!locked_s)           state_d = ST_WAIT_LOCK;
                else if (soft_reset_req) state_d = ST_HOLD;
            end
            ST_PLL_RST: begin
                // locked_s is deliberately ignored while the PLL is held in reset.
                if (cnt_q == PLLRST_LAST) state_d = ST_WAIT_LOCK;
                else                      cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_WAIT_LOCK;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Outputs are decoded from the next state so the flops line up with
        // the state register rather than lagging it by a cycle.
        sys_reset_d  = (state_d != ST_RUN);
        ready_d      = (state_d == ST_RUN);
        pll_resetb_d = (state_d != ST_PLL_RST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            pll_resetb_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            pll_resetb_q <= pll_resetb_d;
        end
    end

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign pll_resetb = pll_resetb_q;

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic              lock_loss;
    logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;

    assign lock_loss = (state_q == ST_RUN) && !locked_s;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (lock_loss && (loss_cnt_q != '1)) loss_cnt_d = loss_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_lost_count = loss_cnt_q;
    assign state_dbg       = state_q;
`else
    assign lock_lost_count = '0;
    assign state_dbg       = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios plus random lock/soft
// reset traffic, every cycle compared against a phase/dwell reference model.
module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int RHC  = 4;
    localparam int TO   = 32;
    localparam int PRC  = 4;

    // phase numbering is the externally visible state_dbg encoding
    localparam int PH_W = 0, PH_Q = 1, PH_H = 2, PH_R = 3, PH_P = 4;

    logic       clk = 1'b0;
    logic       reset, locked, soft_reset_req;
    logic       pll_resetb, sys_reset, ready;
    logic [7:0] lock_lost_count;
    logic [2:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_phase, m_age, m_loss;
    bit lkq[$];

    always #5 clk = ~clk;

    pll_reset_sequencer #(
        .SYNC_STAGES       (SYNC),
        .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES (RHC),
        .RELOCK_TIMEOUT    (TO),
        .PLL_RST_CYCLES    (PRC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .locked         (locked),
        .soft_reset_req (soft_reset_req),
        .pll_resetb     (pll_resetb),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .lock_lost_count(lock_lost_count),
        .state_dbg      (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int dwell(input int ph);
        case (ph)
            PH_W:    return TO;
            PH_Q:    return LSC;
            PH_H:    return RHC;
            PH_P:    return PRC;
            default: return 0;
        endcase
    endfunction

    // One clock edge of the model: locked is seen SYNC edges late, each
    // timed phase lasts dwell(phase) edges unless lock status interrupts.
    task automatic model_edge(input logic lk, input logic sr, input logic rst);
        bit ls;
        int nxt;
        if (rst) begin
            m_phase = PH_W; m_age = 0; m_loss = 0;
            lkq.delete();
            repeat (SYNC) lkq.push_back(1'b0);
            return;
        end
        ls = lkq.pop_front();
        lkq.push_back(lk);
        nxt = m_phase;
        if (m_phase == PH_R) begin
            if (!ls) begin
                nxt = PH_W;
                if (m_loss < 255) m_loss++;
            end else if (sr) begin
                nxt = PH_H;
            end
        end else if (m_phase == PH_P) begin
            if (m_age + 1 == dwell(PH_P)) nxt = PH_W;
        end else if (m_phase == PH_W) begin
            if (ls) nxt = PH_Q;
            else if (m_age + 1 == dwell(PH_W)) nxt = PH_P;
        end else begin
            if (!ls) nxt = PH_W;
            else if (m_age + 1 == dwell(m_phase)) nxt = m_phase + 1;
        end
        m_age   = (nxt == m_phase) ? m_age + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic step(input logic lk, input logic sr, input logic rst);
        int exp_cnt, exp_st;
        locked = lk; soft_reset_req = sr; reset = rst;
        @(posedge clk);
        model_edge(lk, sr, rst);
        #1;
`ifdef PLL_SEQ_LOSS_COUNT_EN
        exp_cnt = m_loss; exp_st = m_phase;
`else
        exp_cnt = 0; exp_st = 0;
`endif
        chk("sys_reset",  32'(sys_reset),       32'(m_phase != PH_R));
        chk("ready",      32'(ready),           32'(m_phase == PH_R));
        chk("pll_resetb", 32'(pll_resetb),      32'(m_phase != PH_P));
        chk("loss_count", 32'(lock_lost_count), 32'(exp_cnt));
        chk("state_dbg",  32'(state_dbg),       32'(exp_st));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60 && ready !== 1'b1; i++) step(1'b1, 1'b0, 1'b0);
        chk(tag, 32'(ready), 32'd1);
    endtask

    initial begin
        int first, starts[2], nstart, lows, hi, lat;
        bit prev, lk;
        int run;

        // reset state
        do_reset();
        chk("rst_sys_reset",  32'(sys_reset),       32'd1);
        chk("rst_ready",      32'(ready),           32'd0);
        chk("rst_pll_resetb", 32'(pll_resetb),      32'd1);
        chk("rst_loss",       32'(lock_lost_count), 32'd0);
        chk("rst_state",      32'(state_dbg),       32'd0);

        // nominal lock-to-release latency
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (first == 0 && sys_reset === 1'b0) first = i;
        end
        chk("nominal_latency", 32'(first), 32'(SYNC + LSC + RHC + 1));

        // lock glitch restarts qualification
        do_reset();
        repeat (5) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (first == 0 && sys_reset === 1'b0) first = i;
        end
        chk("glitch_latency", 32'(first), 32'(SYNC + LSC + RHC + 1));

        // relock timeout and repeated PLL reset pulses
        do_reset();
        nstart = 0; lows = 0; prev = 1'b1;
        starts[0] = 0; starts[1] = 0;
        for (int i = 1; i <= 80; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (pll_resetb === 1'b0) begin
                lows++;
                if (prev && nstart < 2) begin starts[nstart] = i; nstart++; end
            end
            prev = pll_resetb;
        end
        chk("timeout_first", 32'(starts[0]), 32'(TO));
        chk("timeout_second", 32'(starts[1]), 32'(2 * TO + PRC));
        chk("timeout_low_cycles", 32'(lows), 32'(2 * PRC));

        // reset abort in the second PLL_RST cycle
        do_reset();
        repeat (TO + 1) step(1'b0, 1'b0, 1'b0);
        chk("abort_in_pllrst", 32'(pll_resetb), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        chk("abort_pll_resetb", 32'(pll_resetb), 32'd1);
        chk("abort_state", 32'(state_dbg), 32'd0);
        chk("abort_loss", 32'(lock_lost_count), 32'd0);

        // soft reset alone in RUN
        do_reset();
        wait_ready("soft_ready0");
        step(1'b1, 1'b1, 1'b0);
        hi = 0;
        for (int i = 0; i < 12 && ready !== 1'b1; i++) begin
            if (sys_reset === 1'b1) hi++;
            step(1'b1, 1'b0, 1'b0);
        end
        chk("soft_hold_cycles", 32'(hi), 32'(RHC));

        // soft reset coincident with lock loss: loss wins
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("simul_sys_reset", 32'(sys_reset), 32'd1);

        // lock loss repeated until the counter saturates
        do_reset();
        for (int k = 0; k < 300; k++) begin
            wait_ready("loss_ready");
            lat = 0;
            for (int i = 1; i <= 10 && lat == 0; i++) begin
                step(1'b0, 1'b0, 1'b0);
                if (sys_reset === 1'b1) lat = i;
            end
            chk("loss_latency", 32'(lat), 32'(SYNC + 1));
        end
`ifdef PLL_SEQ_LOSS_COUNT_EN
        chk("loss_saturated", 32'(lock_lost_count), 32'd255);
`else
        chk("loss_disabled", 32'(lock_lost_count), 32'd0);
`endif

        // random lock traffic with soft requests and occasional resets
        lk = 1'b0; run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                lk  = ~lk;
                run = lk ? $urandom_range(1, 40) : $urandom_range(1, 50);
            end
            run--;
            step(lk, ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
